// File: rtl/avalon_pkt_drop_fifo_if.sv
// avalon_pkt_drop_fifo_if: Avalon-ST packet stream carrying sop/eop/error/empty/data
interface avalon_pkt_drop_fifo_if #(parameter int DATA_WIDTH = 64);
  logic                  valid;
  logic                  sop;
  logic                  eop;
  logic                  error;
  logic [2:0]            empty;
  logic [DATA_WIDTH-1:0] data;
  logic                  ready;
  modport master (output valid, sop, eop, error, empty, data, input ready);
  modport slave  (input valid, sop, eop, error, empty, data, output ready);
endinterface

// File: rtl/avalon_pkt_drop_fifo.sv
// avalon_pkt_drop_fifo: store-and-forward ingress buffer that drops whole packets that do not fit
module avalon_pkt_drop_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  avalon_pkt_drop_fifo_if.slave  i_snk,
  avalon_pkt_drop_fifo_if.master o_src,
  output logic [DEPTH_LOG2:0]    o_fill,
  output logic [31:0]            o_pkt_cnt,
  output logic [31:0]            o_drop_cnt
);
  localparam int W = DATA_WIDTH + 6;
  localparam logic [DEPTH_LOG2:0] DEPTH_P = {1'b1, {DEPTH_LOG2{1'b0}}};
  typedef enum logic [1:0] {IDLE, WRITE, DISCARD} state_t;
  state_t r_state, w_state_nxt;
  logic [DEPTH_LOG2:0] r_wr_ptr, r_cm_ptr, r_rd_ptr, r_fe_ptr;
  logic [DEPTH_LOG2:0] w_base, w_wr_ptr_nxt, w_cm_ptr_nxt;
  logic w_full, w_acc, w_we, w_commit, w_miss_eop;
  logic [1:0] w_drop_inc;
  logic [32:0] w_pkt_sum, w_drop_sum;
  logic [31:0] r_pkt_cnt, r_drop_cnt;
  logic [W-1:0] r_mem [2**DEPTH_LOG2];
  logic [W-1:0] w_flit, r_q, r_o;
  logic r_q_vld, r_o_valid, w_fetch, w_out_load;
  assign w_flit     = {i_snk.sop, i_snk.eop, i_snk.error, i_snk.empty, i_snk.data};
  // a sop arriving mid-packet rewinds first, so the new packet is placed at the commit pointer
  assign w_miss_eop = i_snk.valid && i_snk.sop && r_state == WRITE;
  assign w_base     = w_miss_eop ? r_cm_ptr : r_wr_ptr;
  assign w_full     = (w_base - r_rd_ptr) == DEPTH_P;
  assign w_pkt_sum  = {1'b0, r_pkt_cnt} + {32'b0, w_commit};
  assign w_drop_sum = {1'b0, r_drop_cnt} + {31'b0, w_drop_inc};
  // write FSM state register
  always_ff @(posedge clk)
    r_state <= !reset ? IDLE : w_state_nxt;
  // write FSM next state: sop always restarts, DISCARD only waits for eop
  always_comb begin
    w_state_nxt = r_state;
    if (i_snk.valid)
      w_state_nxt = (i_snk.sop || r_state == WRITE) ? (i_snk.eop ? IDLE : (w_full ? DISCARD : WRITE)) :
                    (r_state == DISCARD && i_snk.eop) ? IDLE : r_state;
  end
  // write FSM outputs: write enable, pointer moves and counter increments
  always_comb begin
    w_acc        = i_snk.valid && (i_snk.sop || r_state == WRITE);
    w_we         = w_acc && !w_full;
    w_commit     = w_we && i_snk.eop;
    w_wr_ptr_nxt = w_we ? w_base + 1'b1 : (w_acc ? r_cm_ptr : r_wr_ptr);
    w_cm_ptr_nxt = w_commit ? w_base + 1'b1 : r_cm_ptr;
    w_drop_inc   = {1'b0, w_miss_eop} + {1'b0, w_acc && w_full};
  end
  // write-side pointers and saturating packet/drop counters
  always_ff @(posedge clk)
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_cm_ptr   <= '0;
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_cm_ptr   <= w_cm_ptr_nxt;
      r_pkt_cnt  <= w_pkt_sum[32] ? '1 : w_pkt_sum[31:0];
      r_drop_cnt <= w_drop_sum[32] ? '1 : w_drop_sum[31:0];
    end
  // flit storage with registered read port
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_base[DEPTH_LOG2-1:0]] <= w_flit;
    if (w_fetch) r_q <= r_mem[r_fe_ptr[DEPTH_LOG2-1:0]];
  end
  // fetch runs ahead of rd_ptr; slots are only freed when the flit leaves the output register
  assign w_out_load = !r_o_valid || o_src.ready;
  assign w_fetch    = (r_fe_ptr != r_cm_ptr) && (!r_q_vld || w_out_load);
  // read pipeline: memory register feeding an output register that holds while stalled
  always_ff @(posedge clk)
    if (!reset) begin
      r_fe_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_q_vld   <= 1'b0;
      r_o_valid <= 1'b0;
      r_o       <= '0;
    end else begin
      if (w_fetch) r_fe_ptr <= r_fe_ptr + 1'b1;
      if (r_o_valid && o_src.ready) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_q_vld <= w_fetch || (r_q_vld && !w_out_load);
      if (w_out_load) r_o_valid <= r_q_vld;
      if (w_out_load && r_q_vld) r_o <= r_q;
    end
  assign i_snk.ready = 1'b1;
  assign o_src.valid = r_o_valid;
  assign {o_src.sop, o_src.eop, o_src.error, o_src.empty, o_src.data} = r_o;
  assign o_fill      = r_wr_ptr - r_rd_ptr;
  assign o_pkt_cnt   = r_pkt_cnt;
  assign o_drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_avalon_pkt_drop_fifo.sv
// tb_avalon_pkt_drop_fifo: directed and random checks of two buffer depths against a packet-level model
module tb_avalon_pkt_drop_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic t_valid = 1'b0, t_sop = 1'b0, t_eop = 1'b0, t_err = 1'b0, t_ready = 1'b0;
  logic [2:0] t_empty = '0;
  logic [63:0] t_data = '0;
  logic [9:0] fill_a;
  logic [4:0] fill_b;
  logic [31:0] pkt_a, drop_a, pkt_b, drop_b;
  int checks = 0, errs = 0;
  avalon_pkt_drop_fifo_if #(.DATA_WIDTH(64)) snk_a(), src_a(), snk_b(), src_b();
  always #5 clk = ~clk;
  assign snk_a.valid = t_valid;
  assign snk_a.sop   = t_sop;
  assign snk_a.eop   = t_eop;
  assign snk_a.error = t_err;
  assign snk_a.empty = t_empty;
  assign snk_a.data  = t_data;
  assign snk_b.valid = t_valid;
  assign snk_b.sop   = t_sop;
  assign snk_b.eop   = t_eop;
  assign snk_b.error = t_err;
  assign snk_b.empty = t_empty;
  assign snk_b.data  = t_data;
  assign src_a.ready = t_ready;
  assign src_b.ready = t_ready;
  avalon_pkt_drop_fifo #(.DATA_WIDTH(64), .DEPTH_LOG2(9)) dut_a (
    .clk(clk), .reset(rst_n), .i_snk(snk_a), .o_src(src_a),
    .o_fill(fill_a), .o_pkt_cnt(pkt_a), .o_drop_cnt(drop_a));
  avalon_pkt_drop_fifo #(.DATA_WIDTH(64), .DEPTH_LOG2(4)) dut_b (
    .clk(clk), .reset(rst_n), .i_snk(snk_b), .o_src(src_b),
    .o_fill(fill_b), .o_pkt_cnt(pkt_b), .o_drop_cnt(drop_b));
  logic ov [2];
  logic [69:0] of [2];
  logic [31:0] fl [2], pc [2], dc [2];
  assign ov[0] = src_a.valid;
  assign ov[1] = src_b.valid;
  assign of[0] = {src_a.sop, src_a.eop, src_a.error, src_a.empty, src_a.data};
  assign of[1] = {src_b.sop, src_b.eop, src_b.error, src_b.empty, src_b.data};
  assign fl[0] = 32'(fill_a);
  assign fl[1] = 32'(fill_b);
  assign pc[0] = pkt_a;
  assign pc[1] = pkt_b;
  assign dc[0] = drop_a;
  assign dc[1] = drop_b;
  // packet-level model: partial packet, queue of committed flits awaiting output, counters
  int dep [2] = '{512, 16};
  logic [69:0] part [2][512];
  logic [69:0] expq [2][1024];
  int plen [2], eh [2], et [2], mpkt [2], mdrop [2], ntx [2];
  bit inpkt [2];
  task automatic chk(string tag, logic [69:0] obs, logic [69:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model_reset(int k);
    plen[k] = 0; eh[k] = 0; et[k] = 0; mpkt[k] = 0; mdrop[k] = 0; inpkt[k] = 0;
  endtask
  task automatic commit(int k);
    for (int i = 0; i < plen[k]; i++) begin
      expq[k][et[k] % 1024] = part[k][i];
      et[k]++;
    end
    plen[k] = 0; inpkt[k] = 0; mpkt[k]++;
  endtask
  task automatic model_in(int k, logic [69:0] f);
    logic s, e;
    s = f[69];
    e = f[68];
    if (s) begin
      if (inpkt[k]) begin mdrop[k]++; plen[k] = 0; inpkt[k] = 0; end
      if (et[k] - eh[k] == dep[k]) mdrop[k]++;
      else begin
        part[k][0] = f; plen[k] = 1;
        if (e) commit(k); else inpkt[k] = 1;
      end
    end else if (inpkt[k]) begin
      if (et[k] - eh[k] + plen[k] == dep[k]) begin mdrop[k]++; plen[k] = 0; inpkt[k] = 0; end
      else begin
        part[k][plen[k]] = f; plen[k]++;
        if (e) commit(k);
      end
    end
  endtask
  // one clock: drive at negedge, check outgoing flit, update model at posedge, check state at next negedge
  task automatic step(logic v, logic s, logic e, logic er, logic [2:0] em, logic [63:0] d, logic rdy);
    logic x [2];
    logic h [2];
    logic [70:0] held [2];
    logic [69:0] f;
    t_valid = v; t_sop = s; t_eop = e; t_err = er; t_empty = em; t_data = d; t_ready = rdy;
    f = {s, e, er, em, d};
    for (int k = 0; k < 2; k++) begin
      x[k] = rst_n && ov[k] && rdy;
      h[k] = rst_n && ov[k] && !rdy;
      held[k] = {ov[k], of[k]};
      if (rst_n && ov[k]) chk(k == 0 ? "a_unexpected" : "b_unexpected", 70'(eh[k] != et[k]), 70'(1));
      if (x[k] && eh[k] != et[k]) chk(k == 0 ? "a_flit" : "b_flit", of[k], expq[k][eh[k] % 1024]);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++)
      if (!rst_n) model_reset(k);
      else begin
        if (v) model_in(k, f);
        if (x[k] && eh[k] != et[k]) begin eh[k]++; ntx[k]++; end
      end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk(k == 0 ? "a_fill" : "b_fill", 70'(fl[k]), 70'(et[k] - eh[k] + plen[k]));
      chk(k == 0 ? "a_pkt_cnt" : "b_pkt_cnt", 70'(pc[k]), 70'(mpkt[k]));
      chk(k == 0 ? "a_drop_cnt" : "b_drop_cnt", 70'(dc[k]), 70'(mdrop[k]));
      if (h[k]) chk(k == 0 ? "a_hold" : "b_hold", 70'({ov[k], of[k]}), 70'(held[k]));
    end
  endtask
  task automatic idle(int n, logic rdy);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 3'd0, 64'd0, rdy);
  endtask
  task automatic send(int len, logic rdy);
    for (int i = 0; i < len; i++) step(1, i == 0, i == len - 1, 0, 3'd0, {32'(i), $urandom()}, rdy);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    idle(2, 0);
    rst_n = 1'b1;
    ntx[0] = 0;
    ntx[1] = 0;
  endtask
  task automatic drain(logic toggle);
    for (int i = 0; i < 2000 && (eh[0] != et[0] || eh[1] != et[1]); i++)
      step(0, 0, 0, 0, 3'd0, 64'd0, toggle ? logic'(i % 2) : 1'b1);
    chk("a_drained", 70'(eh[0]), 70'(et[0]));
    chk("b_drained", 70'(eh[1]), 70'(et[1]));
    idle(3, 1);
  endtask
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end
  initial begin
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    do_reset();
    chk("rst_valid", 70'(ov[0]), 70'(0));
    chk("rst_data", of[0], 70'(0));
    chk("snk_ready", 70'(snk_a.ready), 70'(1));
    send(8, 1);
    step(0, 0, 0, 0, 3'd0, 64'd0, 1);
    chk("lat_t1", 70'(ov[0]), 70'(0));
    step(0, 0, 0, 0, 3'd0, 64'd0, 1);
    chk("lat_t2", 70'(ov[0]), 70'(1));
    chk("lat_sop", 70'(src_a.sop), 70'(1));
    drain(0);
    chk("t1_flits", 70'(ntx[0]), 70'(8));
    chk("t1_pkt", 70'(pkt_a), 70'(1));
    chk("t1_fill", 70'(fill_a), 70'(0));
    do_reset();
    send(10, 0);
    send(10, 0);
    chk("t2_drop", 70'(drop_b), 70'(1));
    chk("t2_fill", 70'(fill_b), 70'(10));
    chk("t2_pkt", 70'(pkt_b), 70'(1));
    drain(0);
    chk("t2_b_flits", 70'(ntx[1]), 70'(10));
    chk("t2_a_flits", 70'(ntx[0]), 70'(20));
    do_reset();
    step(1, 1, 0, 0, 3'd1, 64'h11, 1);
    step(1, 0, 0, 0, 3'd2, 64'h22, 1);
    step(1, 0, 0, 0, 3'd3, 64'h33, 1);
    send(4, 1);
    drain(0);
    chk("t3_flits", 70'(ntx[0]), 70'(4));
    chk("t3_pkt", 70'(pkt_a), 70'(1));
    chk("t3_drop", 70'(drop_a), 70'(1));
    do_reset();
    for (int i = 0; i < 10; i++) begin
      rst_n = (i != 3);
      step(1, i == 0, i == 9, 0, 3'd0, 64'(i), 1);
    end
    rst_n = 1'b1;
    idle(4, 1);
    chk("t4_valid", 70'(ov[0]), 70'(0));
    chk("t4_fill", 70'(fill_a), 70'(0));
    chk("t4_pkt", 70'(pkt_a), 70'(0));
    chk("t4_drop", 70'(drop_a), 70'(0));
    do_reset();
    for (int i = 0; i < 20; i++) step(1, i == 0, i == 19, 0, 3'd0, {32'(i), $urandom()}, logic'(i % 2));
    drain(1);
    chk("t5_flits", 70'(ntx[0]), 70'(20));
    chk("t5_b_flits", 70'(ntx[1]), 70'(0));
    do_reset();
    step(1, 1, 1, 1, 3'd5, 64'hDEAD_BEEF_0123_4567, 0);
    idle(2, 0);
    chk("t6_fields", 70'({src_a.valid, src_a.sop, src_a.eop, src_a.error, src_a.empty}), 70'({4'b1111, 3'd5}));
    chk("t6_data", 70'(src_a.data), 70'(64'hDEAD_BEEF_0123_4567));
    chk("t6_pkt", 70'(pkt_a), 70'(1));
    drain(0);
    do_reset();
    for (int p = 0; p < 80; p++) begin
      int len;
      bit trunc;
      len = $urandom_range(1, 24);
      trunc = ($urandom % 8 == 0);
      for (int i = 0; i < len; i++)
        step(1, i == 0, i == len - 1 && !trunc, logic'($urandom % 2), 3'($urandom % 8),
             {$urandom(), $urandom()}, logic'($urandom % 4 != 0));
      if ($urandom % 3 == 0) idle($urandom_range(1, 4), logic'($urandom % 2));
      if ($urandom % 6 == 0) step(1, 0, logic'($urandom % 2), 0, 3'd0, 64'd7, 1);
    end
    step(1, 1, 1, 0, 3'd0, 64'd1, 1);
    drain(0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
